vtj1_intc: RTL and testbench
============================

# vtj1_intc

Parametrised successor to the slot-0 system controller: multiplexes up to 2×32 interrupt request lines into one CPU IRQ, adds per-line level/edge mode with latched pending bits, and provides NTIMERS independent periodic/one-shot tick timers in place of the single baud-derived clock interrupt. Sits in I/O slot zero on the standard 8-bit register bus.

## Interface
- NSLOTS, 16: alpha lines and beta lines per group; 1..32.
- NTIMERS, 2: number of tick timers; 1..16.
- clk  input  1  system clock, rising edge active.
- rst  input  1  asynchronous, active-low reset.
- adr  input  8  register address.
- adr_d1  input  8  adr delayed one cycle; unused, present for slot compatibility.
- red  output  8  read data, registered.
- wrt  input  8  write data.
- wen  input  1  write enable.
- irqa  output  1  OR of all timer pending bits.
- irqb  output  1  constant 0.
- alpha_irqs  input  NSLOTS  alpha line per slot, synchronous to clk.
- beta_irqs  input  NSLOTS  beta line per slot, synchronous to clk.
- tick  input  1  one-cycle timer time-base pulse.
- irq  output  1  combined, filtered IRQ to CPU.

## Operation
- Vector registers (enable, mode, status) are 32-bit little-endian, 4 bytes each; bits at index ≥NSLOTS read 0, ignore writes.
- 0x00–0x03 alpha enable; 0x08–0x0B beta enable.
- 0x10–0x13 alpha mode; 0x18–0x1B beta mode (1 = rising-edge latched, 0 = level).
- 0x40–0x43 alpha status; 0x48–0x4B beta status.
  - Level line: status reads raw input; writes ignored.
  - Edge line: pending latch set when input is 1 and its previous-cycle sample is 0; writing 1 to a bit clears it; same-cycle set and clear → set wins.
  - Changing mode leaves the latch value unchanged; latch unused while level.
- Effective request = enable & status; irq = OR of all effective requests.
- 0x80 (read-only): code of highest-priority effective request, else 0xFF. Priority: alpha[0] highest, through alpha[NSLOTS-1], then beta[0]..beta[NSLOTS-1]. Code = i for alpha[i], NSLOTS+i for beta[i].
- Timer t occupies 0xC0+4t .. 0xC3+4t: +0 reload[7:0], +1 reload[15:8], +2 control (bit0 enable, bit1 one-shot, others read 0), +3 status (bit0 pending, write 1 clears).
  - Control write with enable going 0→1 loads count ← reload.
  - Enabled and tick: if count == 0, set pending, count ← reload, and clear enable if one-shot; otherwise count ← count−1. Period = reload+1 ticks.
  - Reload writes do not disturb a running count.
  - Same-cycle fire and pending-clear → pending stays set.
- Unpopulated addresses read 0, ignore writes.
- Read: red ← register at adr on each clk edge. Write cycle: red ← wrt, register updated.

## Timing
- Reset (rst low, async): enables, modes, edge latches, input samples, timer reloads, counts, controls, pending bits and red all 0. Outputs: irq 0, irqa 0, irqb 0, red 0.
- Read latency 1 cycle: adr at edge N → red valid after edge N.
- Level line: irq combinational from input and enable, same cycle.
- Edge line: rising edge present at edge N → latch set at edge N → irq high after edge N.
- Clear by write at edge N → irq low after edge N unless a new edge arrives at edge N.
- Timer: firing tick at edge N → pending and irqa high after edge N.
- Reset asserted mid-count or with pending bits set: all state cleared immediately; timers stay stopped after release.

## Test plan
- Reset check: rst low mid-run with timer pending and edge latches set → irq=0, irqa=0, red=0; after release read 0x80 → 0xFF.
- Level priority: NSLOTS=16, enable alpha=0x0000, beta=0x0021, drive beta_irqs=0x0021 → irq=1, read 0x80 → 0x10 (16+0); drop beta[0] → 0x15.
- Edge latch: mode alpha[3]=1, enable alpha[3], one-cycle pulse on alpha_irqs[3] → status 0x40 reads 0x08 after pulse gone, irq=1; write 0x08 to 0x40 → 0x00, irq=0; new edge in clear cycle → stays 0x08.
- Periodic timer: reload=3, control=0x01, continuous tick → pending every 4 ticks; clear 0xC3 between fires → irqa pulses periodically; irqb always 0.
- One-shot: reload=0, control=0x03 → fires on first tick, control reads 0x02 afterward, no further fires.
- Width bounds: NSLOTS=32, NTIMERS=16 → beta[31] alone gives 0x80 code 0x3F; timer 15 at 0xFC–0xFF functional; NSLOTS=8 → 0x01–0x03 read 0.

Source files
------------

// File: rtl/vtj1_intc.sv
// Slot-0 interrupt controller: alpha/beta request lines with per-line
// level/edge mode, a priority encoder, and NTIMERS periodic/one-shot tick timers.
module vtj1_intc #(
    parameter int NSLOTS  = 16,
    parameter int NTIMERS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        adr,
    input  logic [7:0]        adr_d1,
    output logic [7:0]        red,
    input  logic [7:0]        wrt,
    input  logic              wen,
    output logic              irqa,
    output logic              irqb,
    input  logic [NSLOTS-1:0] alpha_irqs,
    input  logic [NSLOTS-1:0] beta_irqs,
    input  logic              tick,
    output logic              irq
);

    function automatic logic [NSLOTS-1:0] wr_byte(input logic [NSLOTS-1:0] v,
                                                  input logic [1:0] b,
                                                  input logic [7:0] d);
        logic [NSLOTS-1:0] r;
        r = v;
        for (int k = 0; k < NSLOTS; k++)
            if (k / 8 == int'(b)) r[k] = d[k % 8];
        return r;
    endfunction

    function automatic logic [7:0] rd_byte(input logic [NSLOTS-1:0] v,
                                           input logic [1:0] b);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < NSLOTS; k++)
            if (k / 8 == int'(b)) r[k % 8] = v[k];
        return r;
    endfunction

    logic [NSLOTS-1:0] a_en_q, a_en_d, b_en_q, b_en_d;
    logic [NSLOTS-1:0] a_mode_q, a_mode_d, b_mode_q, b_mode_d;
    logic [NSLOTS-1:0] a_lat_q, a_lat_d, b_lat_q, b_lat_d;
    logic [NSLOTS-1:0] a_prev_q, b_prev_q;
    logic [NSLOTS-1:0] a_clr, b_clr;
    logic [NSLOTS-1:0] a_stat, b_stat, a_eff, b_eff;
    logic [7:0]        red_q, red_d, rdata, code;

    logic [15:0] reload_q [NTIMERS];
    logic [15:0] reload_d [NTIMERS];
    logic [15:0] count_q  [NTIMERS];
    logic [15:0] count_d  [NTIMERS];
    logic        ten_q    [NTIMERS];
    logic        ten_d    [NTIMERS];
    logic        tos_q    [NTIMERS];
    logic        tos_d    [NTIMERS];
    logic        pend_q   [NTIMERS];
    logic        pend_d   [NTIMERS];
    logic [NTIMERS-1:0] pend_vec, fire;

    logic [1:0] bsel;
    logic [3:0] tsel;
    logic       tmr_hit;
    logic       unused_ok;

    assign bsel    = adr[1:0];
    assign tsel    = adr[5:2];
    assign tmr_hit = (adr[7:6] == 2'b11) && (int'(tsel) < NTIMERS);
    assign unused_ok = &{1'b0, adr_d1};

    // Edge-mode lines report their latch, level-mode lines the raw input.
    assign a_stat = (a_mode_q & a_lat_q) | (~a_mode_q & alpha_irqs);
    assign b_stat = (b_mode_q & b_lat_q) | (~b_mode_q & beta_irqs);
    assign a_eff  = a_en_q & a_stat;
    assign b_eff  = b_en_q & b_stat;
    assign irq    = |{a_eff, b_eff};
    assign irqa   = |pend_vec;
    assign irqb   = 1'b0;
    assign red    = red_q;

    // Scan from lowest to highest priority so the last hit wins.
    always_comb begin
        code = 8'hFF;
        for (int i = NSLOTS - 1; i >= 0; i--)
            if (b_eff[i]) code = 8'(NSLOTS + i);
        for (int i = NSLOTS - 1; i >= 0; i--)
            if (a_eff[i]) code = 8'(i);
    end

    always_comb begin
        rdata = 8'h00;
        case (adr[7:2])
            6'h00:   rdata = rd_byte(a_en_q, bsel);
            6'h02:   rdata = rd_byte(b_en_q, bsel);
            6'h04:   rdata = rd_byte(a_mode_q, bsel);
            6'h06:   rdata = rd_byte(b_mode_q, bsel);
            6'h10:   rdata = rd_byte(a_stat, bsel);
            6'h12:   rdata = rd_byte(b_stat, bsel);
            6'h20:   rdata = (bsel == 2'd0) ? code : 8'h00;
            default: begin
                for (int t = 0; t < NTIMERS; t++) begin
                    if (tmr_hit && tsel == 4'(t)) begin
                        case (bsel)
                            2'd0: rdata = reload_q[t][7:0];
                            2'd1: rdata = reload_q[t][15:8];
                            2'd2: rdata = {6'b0, tos_q[t], ten_q[t]};
                            default: rdata = {7'b0, pend_q[t]};
                        endcase
                    end
                end
            end
        endcase
        red_d = wen ? wrt : rdata;
    end

    always_comb begin
        a_en_d   = a_en_q;
        b_en_d   = b_en_q;
        a_mode_d = a_mode_q;
        b_mode_d = b_mode_q;
        a_clr    = '0;
        b_clr    = '0;
        if (wen) begin
            case (adr[7:2])
                6'h00: a_en_d   = wr_byte(a_en_q, bsel, wrt);
                6'h02: b_en_d   = wr_byte(b_en_q, bsel, wrt);
                6'h04: a_mode_d = wr_byte(a_mode_q, bsel, wrt);
                6'h06: b_mode_d = wr_byte(b_mode_q, bsel, wrt);
                6'h10: a_clr    = wr_byte('0, bsel, wrt);
                6'h12: b_clr    = wr_byte('0, bsel, wrt);
                default: ;
            endcase
        end
        // A fresh rising edge overrides a same-cycle clear.
        a_lat_d = (a_lat_q & ~(a_clr & a_mode_q)) | (a_mode_q & alpha_irqs & ~a_prev_q);
        b_lat_d = (b_lat_q & ~(b_clr & b_mode_q)) | (b_mode_q & beta_irqs & ~b_prev_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_en_q   <= '0;
            b_en_q   <= '0;
            a_mode_q <= '0;
            b_mode_q <= '0;
            a_lat_q  <= '0;
            b_lat_q  <= '0;
            a_prev_q <= '0;
            b_prev_q <= '0;
            red_q    <= '0;
        end else begin
            a_en_q   <= a_en_d;
            b_en_q   <= b_en_d;
            a_mode_q <= a_mode_d;
            b_mode_q <= b_mode_d;
            a_lat_q  <= a_lat_d;
            b_lat_q  <= b_lat_d;
            a_prev_q <= alpha_irqs;
            b_prev_q <= beta_irqs;
            red_q    <= red_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NTIMERS; gi++) begin : g_tmr
            logic hit;
            assign hit          = wen && tmr_hit && (tsel == 4'(gi));
            assign fire[gi]     = ten_q[gi] && tick && (count_q[gi] == 16'd0);
            assign pend_vec[gi] = pend_q[gi];

            always_comb begin
                reload_d[gi] = reload_q[gi];
                count_d[gi]  = count_q[gi];
                ten_d[gi]    = ten_q[gi];
                tos_d[gi]    = tos_q[gi];
                pend_d[gi]   = pend_q[gi];
                if (ten_q[gi] && tick) begin
                    if (fire[gi]) begin
                        count_d[gi] = reload_q[gi];
                        if (tos_q[gi]) ten_d[gi] = 1'b0;
                    end else begin
                        count_d[gi] = count_q[gi] - 16'd1;
                    end
                end
                if (hit) begin
                    case (bsel)
                        2'd0: reload_d[gi][7:0]  = wrt;
                        2'd1: reload_d[gi][15:8] = wrt;
                        2'd2: begin
                            if (!ten_q[gi] && wrt[0]) count_d[gi] = reload_q[gi];
                            ten_d[gi] = wrt[0];
                            tos_d[gi] = wrt[1];
                        end
                        default: if (wrt[0]) pend_d[gi] = 1'b0;
                    endcase
                end
                if (fire[gi]) pend_d[gi] = 1'b1;
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    reload_q[gi] <= '0;
                    count_q[gi]  <= '0;
                    ten_q[gi]    <= 1'b0;
                    tos_q[gi]    <= 1'b0;
                    pend_q[gi]   <= 1'b0;
                end else begin
                    reload_q[gi] <= reload_d[gi];
                    count_q[gi]  <= count_d[gi];
                    ten_q[gi]    <= ten_d[gi];
                    tos_q[gi]    <= tos_d[gi];
                    pend_q[gi]   <= pend_d[gi];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_vtj1_intc.sv
// Randomised bench for vtj1_intc: per-line/per-timer reference model feeds a
// scoreboard queue; a monitor compares red/irq/irqa/irqb once per cycle.
module tb_vtj1_intc;
    localparam int NS = 16;
    localparam int NT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    adr = '0, adr_d1 = '0, wrt = '0;
    logic          wen = 1'b0, tick = 1'b0;
    logic [NS-1:0] alpha_irqs = '0, beta_irqs = '0;
    logic [7:0]    red;
    logic          irqa, irqb, irq;

    vtj1_intc #(.NSLOTS(NS), .NTIMERS(NT)) dut (
        .clk(clk), .rst(rst), .adr(adr), .adr_d1(adr_d1), .red(red),
        .wrt(wrt), .wen(wen), .irqa(irqa), .irqb(irqb),
        .alpha_irqs(alpha_irqs), .beta_irqs(beta_irqs), .tick(tick), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) adr_d1 <= adr;

    // Reference model: one entry per line, line number == priority code.
    bit m_en [2*NS];
    bit m_mode [2*NS];
    bit m_lat [2*NS];
    bit m_prev [2*NS];
    int m_reload [NT];
    int m_count [NT];
    bit m_ten [NT];
    bit m_tos [NT];
    bit m_pend [NT];
    logic [7:0] m_red;

    typedef struct {
        logic [7:0] adr;
        logic [7:0] red;
        logic       irq;
        logic       irqa;
    } exp_t;
    exp_t sbq[$];

    int n_checks = 0;
    int n_pass = 0;
    logic          drv_rst = 1'b1;
    logic [NS-1:0] drv_alpha = '0, drv_beta = '0;

    function automatic bit raw(input int l);
        return (l < NS) ? alpha_irqs[l] : beta_irqs[l - NS];
    endfunction

    function automatic bit m_status(input int l);
        return m_mode[l] ? m_lat[l] : raw(l);
    endfunction

    function automatic int m_code();
        for (int l = 0; l < 2 * NS; l++)
            if (m_en[l] && m_status(l)) return l;
        return 255;
    endfunction

    function automatic bit m_pend_any();
        for (int t = 0; t < NT; t++)
            if (m_pend[t]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] m_read(input logic [7:0] a);
        logic [7:0] v;
        int hi, by, t, l;
        v = '0;
        hi = int'(a) >> 3;
        by = int'(a) % 4;
        if (a == 8'h80) return 8'(m_code());
        if (a >= 8'hC0) begin
            t = (int'(a) - 'hC0) / 4;
            if (t < NT) begin
                case (by)
                    0: v = 8'(m_reload[t] % 256);
                    1: v = 8'(m_reload[t] / 256);
                    2: v = {6'b0, m_tos[t], m_ten[t]};
                    default: v = {7'b0, m_pend[t]};
                endcase
            end
            return v;
        end
        if (a[2] == 1'b0 && (hi inside {0, 1, 2, 3, 8, 9})) begin
            for (int k = 0; k < 8; k++) begin
                if (by * 8 + k < NS) begin
                    l = (hi % 2) * NS + by * 8 + k;
                    case (hi / 2)
                        0: v[k] = m_en[l];
                        1: v[k] = m_mode[l];
                        default: v[k] = m_status(l);
                    endcase
                end
            end
        end
        return v;
    endfunction

    task automatic m_reset();
        for (int l = 0; l < 2 * NS; l++) begin
            m_en[l] = 0; m_mode[l] = 0; m_lat[l] = 0; m_prev[l] = 0;
        end
        for (int t = 0; t < NT; t++) begin
            m_reload[t] = 0; m_count[t] = 0; m_ten[t] = 0; m_tos[t] = 0; m_pend[t] = 0;
        end
        m_red = '0;
    endtask

    task automatic m_step(input logic [7:0] a, input logic w, input logic [7:0] d, input logic tk);
        logic [7:0] nred;
        bit nlat [2*NS];
        bit clr, fire, old_ten;
        int hi, by, idx, l;
        nred = w ? d : m_read(a);
        hi = int'(a) >> 3;
        by = int'(a) % 4;
        for (int j = 0; j < 2 * NS; j++) begin
            idx = j % NS;
            clr = w && a[2] == 1'b0 && hi == 8 + j / NS && idx / 8 == by && d[idx % 8];
            if (m_mode[j] && raw(j) && !m_prev[j]) nlat[j] = 1;
            else if (m_mode[j] && clr)             nlat[j] = 0;
            else                                   nlat[j] = m_lat[j];
        end
        for (int j = 0; j < 2 * NS; j++) begin
            m_lat[j] = nlat[j];
            m_prev[j] = raw(j);
        end
        if (w && a[2] == 1'b0 && hi < 4) begin
            for (int k = 0; k < 8; k++) begin
                if (by * 8 + k < NS) begin
                    l = (hi % 2) * NS + by * 8 + k;
                    if (hi < 2) m_en[l] = d[k];
                    else        m_mode[l] = d[k];
                end
            end
        end
        for (int t = 0; t < NT; t++) begin
            fire = m_ten[t] && tk && m_count[t] == 0;
            old_ten = m_ten[t];
            if (m_ten[t] && tk) begin
                if (fire) begin
                    m_count[t] = m_reload[t];
                    if (m_tos[t]) m_ten[t] = 0;
                end else begin
                    m_count[t] = m_count[t] - 1;
                end
            end
            if (w && a >= 8'hC0 && (int'(a) - 'hC0) / 4 == t) begin
                case (by)
                    0: m_reload[t] = (m_reload[t] / 256) * 256 + int'(d);
                    1: m_reload[t] = (m_reload[t] % 256) + int'(d) * 256;
                    2: begin
                        if (!old_ten && d[0]) m_count[t] = m_reload[t];
                        m_ten[t] = d[0];
                        m_tos[t] = d[1];
                    end
                    default: if (d[0]) m_pend[t] = 0;
                endcase
            end
            if (fire) m_pend[t] = 1;
        end
        m_red = nred;
    endtask

    // One bus cycle: drive at negedge, record what the DUT must show before the next edge.
    task automatic cyc(input logic [7:0] a, input logic w = 1'b0,
                       input logic [7:0] d = 8'h00, input logic tk = 1'b0);
        exp_t e;
        @(negedge clk);
        rst = drv_rst; adr = a; wen = w; wrt = d; tick = tk;
        alpha_irqs = drv_alpha; beta_irqs = drv_beta;
        if (!drv_rst) m_reset();
        e.adr = a;
        e.red = m_red;
        e.irq = (m_code() != 255);
        e.irqa = m_pend_any();
        sbq.push_back(e);
        if (drv_rst) m_step(a, w, d, tk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                n_checks++;
                if (red === e.red && irq === e.irq && irqa === e.irqa && irqb === 1'b0) begin
                    n_pass++;
                    $display("ok   #%0d adr=%02h red=%02h irq=%b irqa=%b", n_checks, e.adr, red, irq, irqa);
                end else begin
                    $display("FAIL cycle#%0d adr=%02h: got red=%02h irq=%b irqa=%b irqb=%b, want red=%02h irq=%b irqa=%b irqb=0",
                             n_checks, e.adr, red, irq, irqa, irqb, e.red, e.irq, e.irqa);
                end
            end
        end
    end

    logic [7:0] addr_pool [24] = '{8'h00, 8'h01, 8'h02, 8'h08, 8'h09, 8'h0A, 8'h10, 8'h11,
                                   8'h18, 8'h19, 8'h40, 8'h41, 8'h48, 8'h49, 8'h80, 8'h80,
                                   8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC6, 8'hC7, 8'hC8};

    initial begin : stim
        logic [7:0] a, d;
        logic w;
        m_reset();
        drv_rst = 1'b0;
        repeat (3) cyc(8'h80);
        drv_rst = 1'b1;
        repeat (2) cyc(8'h80);

        // Level priority on beta lines.
        cyc(8'h08, 1'b1, 8'h21);
        cyc(8'h09, 1'b1, 8'h00);
        drv_beta = 16'h0021;
        repeat (2) cyc(8'h80);
        drv_beta = 16'h0020;
        repeat (2) cyc(8'h80);
        drv_beta = 16'h0000;

        // Edge latch on alpha[3]: set, clear, clear racing a new edge.
        cyc(8'h10, 1'b1, 8'h08);
        cyc(8'h00, 1'b1, 8'h08);
        drv_alpha = 16'h0008; cyc(8'h40);
        drv_alpha = 16'h0000; repeat (2) cyc(8'h40);
        cyc(8'h40, 1'b1, 8'h08);
        repeat (2) cyc(8'h40);
        drv_alpha = 16'h0008; cyc(8'h40, 1'b1, 8'h08);
        drv_alpha = 16'h0000; repeat (2) cyc(8'h40);
        cyc(8'h40, 1'b1, 8'h08);

        // Unpopulated bytes and absent timer.
        cyc(8'h02, 1'b1, 8'hFF);
        cyc(8'h02); cyc(8'hC8, 1'b1, 8'h01); cyc(8'hC8); cyc(8'h20);

        // Periodic timer 0, reload 3.
        cyc(8'hC0, 1'b1, 8'h03);
        cyc(8'hC1, 1'b1, 8'h00);
        cyc(8'hC2, 1'b1, 8'h01);
        for (int i = 0; i < 14; i++) begin
            if (i % 4 == 1) cyc(8'hC3, 1'b1, 8'h01, 1'b1);
            else            cyc(8'hC3, 1'b0, 8'h00, 1'b1);
        end
        cyc(8'hC2, 1'b1, 8'h00);
        cyc(8'hC3, 1'b1, 8'h01);

        // One-shot timer 1, reload 0.
        cyc(8'hC4, 1'b1, 8'h00);
        cyc(8'hC6, 1'b1, 8'h03);
        cyc(8'hC6, 1'b0, 8'h00, 1'b1);
        repeat (3) cyc(8'hC6, 1'b0, 8'h00, 1'b1);
        cyc(8'hC7, 1'b1, 8'h01, 1'b1);
        repeat (3) cyc(8'hC7, 1'b0, 8'h00, 1'b1);

        // Random traffic, with an asynchronous reset mid-run.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700 || i == 701) drv_rst = 1'b0;
            else drv_rst = 1'b1;
            if ($urandom_range(0, 3) == 0) drv_alpha = NS'($urandom);
            if ($urandom_range(0, 3) == 0) drv_beta = NS'($urandom) & NS'($urandom);
            a = ($urandom_range(0, 9) == 0) ? 8'($urandom) : addr_pool[$urandom_range(0, 23)];
            w = ($urandom_range(0, 3) == 0);
            d = 8'($urandom);
            if (a inside {8'hC0, 8'hC4}) d = 8'($urandom_range(0, 5));
            if (a inside {8'hC1, 8'hC5}) d = 8'h00;
            cyc(a, w, d, 1'($urandom_range(0, 1)));
        end

        // Reset with state populated, then confirm idle priority code.
        drv_rst = 1'b1;
        cyc(8'h10, 1'b1, 8'hFF);
        cyc(8'h00, 1'b1, 8'hFF);
        cyc(8'hC2, 1'b1, 8'h01);
        drv_alpha = 16'h00FF; cyc(8'h40, 1'b0, 8'h00, 1'b1);
        drv_alpha = 16'h0000; cyc(8'h40);
        drv_rst = 1'b0;
        repeat (2) cyc(8'h80);
        drv_rst = 1'b1;
        repeat (3) cyc(8'h80, 1'b0, 8'h00, 1'b1);
        cyc(8'hC2);

        repeat (2) @(negedge clk);
        #5;
        if (sbq.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sbq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
